iob_ram_sp_arbiter: RTL
=======================

Name: iob_ram_sp_arbiter

Overview:
- Round-robin arbiter sharing one single-port synchronous RAM (en/we/addr/din/dout, registered read) among N_REQ requesters.
- Sits between several masters (e.g. CPU data port, DMA, debug loader) and one RAM instance.
- Grants at most one access per cycle and returns read data one cycle after the grant.
- Sustains back-to-back accesses at full RAM bandwidth.

Parameters:
- N_REQ, 2, number of requesters; legal range 2..8.
- DATA_W, 8, RAM data width.
- ADDR_W, 14, RAM address width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  N_REQ  bit i: requester i has an access pending.
- req_we  input  N_REQ  bit i: 1 = write, 0 = read.
- req_addr  input  N_REQ*ADDR_W  requester i address in slice [i*ADDR_W +: ADDR_W].
- req_wdata  input  N_REQ*DATA_W  requester i write data in slice [i*DATA_W +: DATA_W].
- req_ready  output  N_REQ  one-hot grant; access accepted this cycle.
- resp_valid  output  N_REQ  bit i: resp_rdata holds requester i read data this cycle.
- resp_rdata  output  DATA_W  read data shared by all requesters; qualified by resp_valid.
- ram_en  output  1  RAM enable.
- ram_we  output  1  RAM write enable.
- ram_addr  output  ADDR_W  RAM address.
- ram_din  output  DATA_W  RAM write data.
- ram_dout  input  DATA_W  RAM registered read data.

Behaviour:
- Clock and reset: one clock domain, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - priority pointer ptr = 0 (requester 0 highest priority).
  - resp_valid = 0; internal read-pending flag and owner index = 0.
  - req_ready, ram_en, ram_we are combinational and evaluate to 0 while req_valid = 0.
- Arbitration (combinational, same cycle):
  - Search req_valid starting at index ptr, ascending, wrapping N_REQ-1 -> 0.
  - The first asserted index g is granted: req_ready = one-hot(g).
  - ram_en = |req_valid; ram_we = req_we[g]; ram_addr and ram_din = slices g.
  - When no request is pending: req_ready = 0, ram_en = 0, ram_we = 0; ram_addr and ram_din are don't-care (drive slice 0).
  - req_ready depends only on req_valid and ptr. No path from req_ready back to any input.
- Pointer update (registered):
  - On a grant to g: ptr <= (g+1) mod N_REQ.
  - No grant: ptr holds.
- Read response:
  - Read granted in cycle T -> resp_valid[g] = 1 in cycle T+1 for exactly one cycle.
  - resp_rdata = ram_dout, passed through directly with no extra register. Latency is 1 cycle.
- Write response: none. A write is complete when req_ready is sampled high.
- Throughput and response ordering:
  - One access per cycle; back-to-back grants allowed, to the same or different requesters.
  - At most one bit of resp_valid is high per cycle.
  - A write granted in T+1 while a read response is due in T+1 is legal. The RAM does not update dout on a write, so the response stays correct.
- resp_rdata when resp_valid = 0: holds the last RAM dout; don't-care.
- Requester rule (not checked by the arbiter): address, we and wdata stay stable while valid is high until ready.
  - A requester may drop valid before ready; the arbiter then simply does not grant it.
- Fairness: with all N_REQ requesting continuously, each is granted exactly once every N_REQ cycles.
- Reset mid-operation:
  - A pending read response is discarded; resp_valid = 0 immediately (asynchronous).
  - ptr returns to 0.

Test Plan:
- Reset then single read: rst_n low 3 cycles, RAM preloaded addr 5 = 0xA5; req0 reads addr 5 at T -> req_ready = 01 at T; resp_valid = 01 and resp_rdata = 0xA5 at T+1; zero otherwise.
- Contention, N_REQ = 2: both valid continuously from T, req0 reads addr 1, req1 reads addr 2 -> grants 01,10,01,10 at T..T+3; resp_valid 01,10,... from T+1 with matching data.
- Write then read-back: req1 writes 0x3C to addr 0x3FFF (top address); next cycle req0 reads 0x3FFF -> resp_valid = 01 with 0x3C; no resp_valid for the write cycle.
- Pointer hold and wrap, N_REQ = 4: grant req3 -> ptr = 0; idle 5 cycles, ptr unchanged; then req1 and req2 request -> req1 granted first.
- Reset mid-read: read granted at T, rst_n low at T+0.5 -> resp_valid = 0 at T+1; after release, req1 and req0 both request -> req0 granted first.
- Random stress: 10k cycles, random valid/we/addr on 3 requesters against a scoreboard model -> every read data matches; each requester granted within N_REQ cycles of asserting valid.

Source files
------------

// File: rtl/iob_ram_sp_arbiter.sv
// Round-robin arbiter that shares one single-port synchronous RAM among N_REQ requesters.
// Grants are combinational; read data returns one cycle after the grant, straight from ram_dout.
module iob_ram_sp_arbiter #(
    parameter int N_REQ  = 2,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 14
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ-1:0]          req_we,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_wdata,
    output logic [N_REQ-1:0]          req_ready,
    output logic [N_REQ-1:0]          resp_valid,
    output logic [DATA_W-1:0]         resp_rdata,
    output logic                      ram_en,
    output logic                      ram_we,
    output logic [ADDR_W-1:0]         ram_addr,
    output logic [DATA_W-1:0]         ram_din,
    input  logic [DATA_W-1:0]         ram_dout
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic             rd_pend_q, rd_pend_d;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_any;
    int               cand;

    // Search from ptr upwards with wrap; the first pending requester wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = 0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!grant_any && req_valid[IDX_W'(cand)]) begin
                grant_any = 1'b1;
                grant_idx = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_any) begin
            req_ready[grant_idx] = 1'b1;
        end
        ram_en   = grant_any;
        ram_we   = grant_any & req_we[grant_idx];
        ram_addr = req_addr[grant_idx*ADDR_W +: ADDR_W];
        ram_din  = req_wdata[grant_idx*DATA_W +: DATA_W];
    end

    always_comb begin
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        rd_pend_d = grant_any & ~req_we[grant_idx];
        if (grant_any) begin
            ptr_d   = (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
            owner_d = grant_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= '0;
            owner_q   <= '0;
            rd_pend_q <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            rd_pend_q <= rd_pend_d;
        end
    end

    // Writes never raise resp_valid; the RAM keeps dout unchanged on a write cycle.
    always_comb begin
        resp_valid = '0;
        if (rd_pend_q) begin
            resp_valid[owner_q] = 1'b1;
        end
    end

    assign resp_rdata = ram_dout;

endmodule
